// File: rtl/operand_collector.sv
// operand_collector
// -----------------
// Gathers the rs/rt operands of every enabled thread of a block from a
// banked thread register file that has one registered read port. A read is
// issued every cycle while collecting; the returned data is written into the
// per-thread rs/rt slots one edge later, guided by a one-deep pipeline tag.
//
// FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE
//   IDLE  : wait for start; latch mask/addresses and clear all slots.
//           An all-zero mask jumps straight to DONE.
//   ISSUE : one read per cycle, enabled threads in ascending order.
//           Single-port: t.rs then t.rt. Dual-port: rs and rt together.
//   DRAIN : no read; the final capture lands at the end of this cycle.
//   DONE  : done pulse for one cycle.
//
// Optional feature: define OPERAND_COLLECTOR_DUAL_PORT_EN to add a second
// read address/data pair so that rs and rt are fetched in the same cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               collection request, sampled only in IDLE
//   thread_enable       active-thread mask, latched on accepted start
//   decoded_rs_address  rs register index, latched on accepted start
//   decoded_rt_address  rt register index, latched on accepted start
//   rf_read_valid       a read is issued this cycle
//   rf_read_thread      target thread bank (0 when no read)
//   rf_read_address     register index (rs in dual-port build; 0 when no read)
//   rf_read_data        data for the read issued in the previous cycle
//   rf_rt_read_address  (dual-port only) rt index, 0 when no read
//   rf_rt_read_data     (dual-port only) rt data for the previous cycle's read
//   rs, rt              flat operand vectors, thread t at [t*DATA_BITS +: DATA_BITS]
//   busy                FSM is not in IDLE
//   done                one-cycle pulse, rs/rt valid and stable
//   fsm_state           debug view of the FSM state (IDLE=0 ISSUE=1 DRAIN=2 DONE=3)
//
// Handshake: start is a level sampled on a rising edge while busy=0; it is
// accepted exactly on that edge and ignored (not queued) while busy=1.
// rf_read_valid is a pure issue strobe; the register file never stalls, so
// rf_read_data is consumed unconditionally one edge after each issue.

module operand_collector #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS = 8,
  localparam int TID_BITS = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [THREADS_PER_BLOCK-1:0]           thread_enable,
  input  logic [3:0]                             decoded_rs_address,
  input  logic [3:0]                             decoded_rt_address,
  output logic                                   rf_read_valid,
  output logic [TID_BITS-1:0]                    rf_read_thread,
  output logic [3:0]                             rf_read_address,
  input  logic [DATA_BITS-1:0]                   rf_read_data,
`ifdef OPERAND_COLLECTOR_DUAL_PORT_EN
  output logic [3:0]                             rf_rt_read_address,
  input  logic [DATA_BITS-1:0]                   rf_rt_read_data,
`endif
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt,
  output logic                                   busy,
  output logic                                   done,
  output logic [1:0]                             fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [THREADS_PER_BLOCK-1:0] mask_q;
  logic [3:0]                   rs_addr_q;
  logic [3:0]                   rt_addr_q;
  logic [TID_BITS-1:0]          cur_thread, cur_thread_nxt;

  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0] rs_q;
  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0] rt_q;

  // Pipeline tag describing the read whose data arrives on the next edge.
  logic                tag_valid;
  logic [TID_BITS-1:0] tag_thread;

`ifndef OPERAND_COLLECTOR_DUAL_PORT_EN
  // Single-port build: 0 = rs read of cur_thread, 1 = rt read.
  logic cur_rt, cur_rt_nxt;
  logic tag_rt;
`endif

  logic                accept;
  logic [TID_BITS:0]   first_en;  // {found, index} over the incoming mask
  logic [TID_BITS:0]   next_en;   // {found, index} above cur_thread

  // Lowest enabled thread strictly above 'after'. Scanning downward lets the
  // last hit (the lowest index) win.
  function automatic logic [TID_BITS:0] find_next(
    input logic [THREADS_PER_BLOCK-1:0] mask,
    input int                           after
  );
    logic [TID_BITS:0] res;
    res = '0;
    for (int t = THREADS_PER_BLOCK - 1; t >= 0; t--) begin
      if (mask[t] && (t > after)) res = {1'b1, TID_BITS'(t)};
    end
    return res;
  endfunction

  assign accept   = (state == IDLE) && start;
  assign first_en = find_next(thread_enable, -1);
  assign next_en  = find_next(mask_q, int'(cur_thread));

  // Next-state and issue outputs
  always_comb begin
    state_nxt       = state;
    cur_thread_nxt  = cur_thread;
    rf_read_valid   = 1'b0;
    rf_read_thread  = '0;
    rf_read_address = '0;
`ifdef OPERAND_COLLECTOR_DUAL_PORT_EN
    rf_rt_read_address = '0;
`else
    cur_rt_nxt      = cur_rt;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          if (|thread_enable) begin
            state_nxt      = ISSUE;
            cur_thread_nxt = first_en[TID_BITS-1:0];
`ifndef OPERAND_COLLECTOR_DUAL_PORT_EN
            cur_rt_nxt     = 1'b0;
`endif
          end else begin
            state_nxt = DONE;
          end
        end
      end

      ISSUE: begin
        rf_read_valid  = 1'b1;
        rf_read_thread = cur_thread;
`ifdef OPERAND_COLLECTOR_DUAL_PORT_EN
        rf_read_address    = rs_addr_q;
        rf_rt_read_address = rt_addr_q;
        if (next_en[TID_BITS]) cur_thread_nxt = next_en[TID_BITS-1:0];
        else                   state_nxt      = DRAIN;
`else
        rf_read_address = cur_rt ? rt_addr_q : rs_addr_q;
        if (!cur_rt) begin
          cur_rt_nxt = 1'b1;
        end else begin
          cur_rt_nxt = 1'b0;
          if (next_en[TID_BITS]) cur_thread_nxt = next_en[TID_BITS-1:0];
          else                   state_nxt      = DRAIN;
        end
`endif
      end

      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mask_q     <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      cur_thread <= '0;
      tag_valid  <= 1'b0;
      tag_thread <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
`ifndef OPERAND_COLLECTOR_DUAL_PORT_EN
      cur_rt     <= 1'b0;
      tag_rt     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cur_thread <= cur_thread_nxt;
      tag_valid  <= rf_read_valid;
      tag_thread <= rf_read_thread;
`ifndef OPERAND_COLLECTOR_DUAL_PORT_EN
      cur_rt     <= cur_rt_nxt;
      tag_rt     <= cur_rt;
`endif
      if (accept) begin
        mask_q    <= thread_enable;
        rs_addr_q <= decoded_rs_address;
        rt_addr_q <= decoded_rt_address;
        rs_q      <= '0;
        rt_q      <= '0;
      end else if (tag_valid) begin
        // tag_valid is never set in IDLE, so capture cannot collide with
        // the slot clear above.
`ifdef OPERAND_COLLECTOR_DUAL_PORT_EN
        rs_q[tag_thread] <= rf_read_data;
        rt_q[tag_thread] <= rf_rt_read_data;
`else
        if (tag_rt) rt_q[tag_thread] <= rf_read_data;
        else        rs_q[tag_thread] <= rf_read_data;
`endif
      end
    end
  end

  assign rs        = rs_q;
  assign rt        = rt_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: doc/operand_collector.md
# operand_collector

Per-core sequencer that gathers `rs`/`rt` operands for every active thread of a block from a shared, banked thread register file with a single registered read port. The core scheduler pulses `start` in its REQUEST state. The collector issues one register-file read per cycle and presents all operands as flat vectors. It raises `done` so the scheduler can advance to EXECUTE.

## Interface
- `THREADS_PER_BLOCK`, 4 — thread slots served; `TID_BITS` = `$clog2(THREADS_PER_BLOCK)`, minimum 1.
- `DATA_BITS`, 8 — register width.

Ports:
- `clk` in 1 — single clock; all state changes on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request collection; sampled only in IDLE.
- `thread_enable` in THREADS_PER_BLOCK — active-thread mask; latched on accepted `start`.
- `decoded_rs_address` in 4 — source register rs; latched on accepted `start`.
- `decoded_rt_address` in 4 — source register rt; latched on accepted `start`.
- `rf_read_valid` out 1 — read issued this cycle.
- `rf_read_thread` out TID_BITS — target thread bank.
- `rf_read_address` out 4 — register index.
- `rf_read_data` in DATA_BITS — data for the read issued in the previous cycle.
- `rs` out THREADS_PER_BLOCK×DATA_BITS — thread t at bits [t*DATA_BITS +: DATA_BITS].
- `rt` out THREADS_PER_BLOCK×DATA_BITS — same packing as `rs`.
- `busy` out 1 — state ≠ IDLE.
- `done` out 1 — one-cycle pulse; `rs`/`rt` are valid and stable.

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- **IDLE**
  - On `start`=1 with nonzero mask: latch mask and both addresses, clear all `rs`/`rt` slots to 0, go to ISSUE.
  - On `start`=1 with mask = 0: clear all slots, go directly to DONE; no reads are issued.
- **ISSUE**
  - Exactly one read per cycle, `rf_read_valid`=1.
  - Order: ascending thread index over enabled threads only, rs then rt per thread (t0.rs, t0.rt, t1.rs, …).
  - Disabled threads are skipped with no idle cycle.
  - After the last rt read is issued, go to DRAIN.
- **Capture**
  - A one-deep pipeline tag (thread, rs/rt) follows each issue.
  - On the next edge, `rf_read_data` is written into the tagged slot.
  - Skipped slots stay 0.
- **DRAIN**
  - `rf_read_valid`=0; the final capture occurs at the end of this cycle.
  - Go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- Outputs `rs`/`rt` hold their values after DONE until the next accepted `start` or `reset`.
- `start` is ignored while `busy`; it is neither queued nor restarted.
- Changes on `thread_enable` or address inputs after acceptance have no effect.
- Address 13–15 reads (read-only registers) are issued like any other address; the register file resolves them.
- **Reset**
  - Applies in any state, including mid-ISSUE: state becomes IDLE and the pipeline tag is invalidated.
  - A read in flight is discarded; `rf_read_data` is not captured on the next edge.
  - Reset values: `rs`=0, `rt`=0, `busy`=0, `done`=0, `rf_read_valid`=0, `rf_read_thread`=0, `rf_read_address`=0.

## Timing
- Cycle n means the cycle after rising edge n; `start` is sampled at edge 0; E = number of enabled threads.
- Reads are issued in cycles 1…2E; data is captured at edges 2…2E+1.
- DRAIN occupies cycle 2E+1; `done` is high in cycle 2E+2; `busy` is high in cycles 1…2E+2.
- A new `start` is accepted at the earliest at edge 2E+3.
- E=0: `done` is high in cycle 1 and `busy` in cycle 1 only.
- `rf_read_thread`/`rf_read_address` are 0 whenever `rf_read_valid`=0.

## Configuration
- `OPERAND_COLLECTOR_DUAL_PORT_EN` defined:
  - Adds ports `rf_rt_read_address` out 4 and `rf_rt_read_data` in DATA_BITS.
  - rs and rt for one thread are read in the same cycle: `rf_read_address` carries rs, `rf_rt_read_address` carries rt.
  - Reads in cycles 1…E, DRAIN in cycle E+1, `done` in cycle E+2.
  - `rf_rt_read_address` is 0 when not valid.
- Undefined: the extra ports are absent and the single-port 2E schedule above applies.

## Test plan
- **All threads enabled.** Mask 4'b1111, rs=R1, rt=R2, register file returns {thread,addr}-unique values → eight reads in order t0.R1, t0.R2 … t3.R2 in cycles 1–8; `done` in cycle 10; every slot matches its read.
- **Sparse mask.** Mask 4'b1010 → four reads in cycles 1–4, threads 1 and 3 only; `done` in cycle 6; slots 0 and 2 read 0.
- **Empty mask.** Mask 0 → no `rf_read_valid`; `done` in cycle 1; all slots 0.
- **Start while busy.** `start` held high through a full operation → exactly one collection; a second starts at edge 2E+3 only if `start` is still high.
- **Reset mid-ISSUE.** `reset` at cycle 3 → cycle 4 shows IDLE, `busy`=0, `rs`=`rt`=0, and no capture of in-flight data.
- **Dual-port build.** With `OPERAND_COLLECTOR_DUAL_PORT_EN`, mask 4'b1111 → four dual reads in cycles 1–4; `done` in cycle 6; same slot values as the all-threads case.
